// File: rtl/text_pkg.sv
// Constants and state type shared by the text writer and the display effect blocks.
package text_pkg;

  localparam int unsigned NUM_SLOTS = 7;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned CHECK_W   = 4;
  localparam int unsigned CHAR_W    = 7;

  localparam logic [CHAR_W-1:0]  CHAR_MAX    = 7'd36;
  localparam logic [CHAR_W-1:0]  BLANK_INDEX = 7'd36;
  localparam logic [CHECK_W-1:0] CHECK_IDLE  = 4'hF;
  localparam logic [SLOT_W-1:0]  LAST_SLOT   = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    SCAN  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Slot index successor, wrapping from the last slot back to 0.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == LAST_SLOT) ? '0 : SLOT_W'(s + 1);
  endfunction

endpackage

// File: rtl/text_writer_if.sv
// Slot-write stream from the text writer to the display effect modules.
interface text_writer_if;
  import text_pkg::*;

  logic [CHECK_W-1:0] check;
  logic [CHAR_W-1:0]  text_index;

  modport master (output check, output text_index);
  modport slave  (input  check, input  text_index);
endinterface

// File: rtl/text_writer_btn_edge.sv
// Rising-edge detector for one debounced, already synchronous push-button.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= btn;
  end

  assign rise_c = btn & ~prev;

endmodule

// File: rtl/text_writer.sv
// Seven-slot character buffer edited from push-buttons and streamed continuously as slot writes.
module text_writer
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              edit_en,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_next,
  input  logic              btn_clear,
  text_writer_if.master     wr,
  output logic [SLOT_W-1:0] cursor,
  output logic              busy
);

  state_e              state, state_nx;
  logic [SLOT_W-1:0]   scan_ptr, scan_ptr_nx, clr_k, clr_k_nx, cursor_nx;
  logic [CHECK_W-1:0]  check_nx;
  logic [CHAR_W-1:0]   text_index_nx;
  logic                busy_nx;
  logic [CHAR_W-1:0]   slots [NUM_SLOTS];
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_slot;
  logic [CHAR_W-1:0]   wr_val, cur_val;
  logic                up_c, down_c, next_c, clear_c, start_clear_c;

  btn_edge u_up    (.clk(clk), .rst(rst), .btn(btn_up),    .rise_c(up_c));
  btn_edge u_down  (.clk(clk), .rst(rst), .btn(btn_down),  .rise_c(down_c));
  btn_edge u_next  (.clk(clk), .rst(rst), .btn(btn_next),  .rise_c(next_c));
  btn_edge u_clear (.clk(clk), .rst(rst), .btn(btn_clear), .rise_c(clear_c));

  assign cur_val       = slots[cursor];
  assign start_clear_c = edit_en & clear_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SCAN:    if (start_clear_c) state_nx = CLEAR;
      CLEAR:   if (clr_k == LAST_SLOT) state_nx = SCAN;
      default: state_nx = SCAN;
    endcase
  end

  // Next values for the registered outputs, pointers and the single buffer write port.
  always_comb begin
    scan_ptr_nx   = scan_ptr;
    clr_k_nx      = clr_k;
    cursor_nx     = cursor;
    busy_nx       = busy;
    check_nx      = wr.check;
    text_index_nx = wr.text_index;
    wr_en         = 1'b0;
    wr_slot       = cursor;
    wr_val        = cur_val;
    case (state)
      SCAN: begin
        if (start_clear_c) begin
          // Clear step k=0 is presented on the same edge that samples the clear button.
          clr_k_nx      = '0;
          busy_nx       = 1'b1;
          check_nx      = '0;
          text_index_nx = BLANK_INDEX;
          wr_en         = 1'b1;
          wr_slot       = '0;
          wr_val        = BLANK_INDEX;
        end else begin
          check_nx      = CHECK_W'(scan_ptr);
          text_index_nx = slots[scan_ptr];
          scan_ptr_nx   = slot_inc(scan_ptr);
          if (edit_en) begin
            if (up_c && !down_c) begin
              wr_en  = 1'b1;
              wr_val = (cur_val == CHAR_MAX) ? '0 : CHAR_W'(cur_val + 1);
            end else if (down_c && !up_c) begin
              wr_en  = 1'b1;
              wr_val = (cur_val == '0) ? CHAR_MAX : CHAR_W'(cur_val - 1);
            end
            if (next_c) cursor_nx = slot_inc(cursor);
          end
        end
      end
      CLEAR: begin
        if (clr_k == LAST_SLOT) begin
          // Leaving CLEAR doubles as the first scan write, slot 0.
          busy_nx       = 1'b0;
          cursor_nx     = '0;
          check_nx      = '0;
          text_index_nx = slots[0];
          scan_ptr_nx   = SLOT_W'(1);
        end else begin
          clr_k_nx      = slot_inc(clr_k);
          check_nx      = CHECK_W'(slot_inc(clr_k));
          text_index_nx = BLANK_INDEX;
          wr_en         = 1'b1;
          wr_slot       = slot_inc(clr_k);
          wr_val        = BLANK_INDEX;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr      <= '0;
      clr_k         <= '0;
      cursor        <= '0;
      busy          <= 1'b0;
      wr.check      <= CHECK_IDLE;
      wr.text_index <= BLANK_INDEX;
    end else begin
      scan_ptr      <= scan_ptr_nx;
      clr_k         <= clr_k_nx;
      cursor        <= cursor_nx;
      busy          <= busy_nx;
      wr.check      <= check_nx;
      wr.text_index <= text_index_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= BLANK_INDEX;
    end else if (wr_en) begin
      slots[wr_slot] <= wr_val;
    end
  end

endmodule
